// File: rtl/cdc_pkg.sv
// Shared constants and types for the slow-domain event collector.
package cdc_pkg;

    localparam int CNT_W_DEFAULT = 4;

    typedef logic [CNT_W_DEFAULT-1:0] pend_cnt_t;

    localparam pend_cnt_t PEND_MAX = {CNT_W_DEFAULT{1'b1}};

endpackage

// File: rtl/pulse_rise_det.sv
// Rising-edge detector on an already-synchronized level; din_d clears to 0 so a
// level that is high when reset releases still reports one rise.
module pulse_rise_det (
    input  logic clkb,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic r_din_d;

    // Delay register for edge detection
    always_ff @(posedge clkb) begin
        if (!rst) begin
            r_din_d <= 1'b0;
        end else begin
            r_din_d <= din;
        end
    end

    assign rise = din & ~r_din_d;

endmodule

// File: rtl/event_collect_s.sv
// Saturating pending-event counter with valid/ready hand-off to a slow consumer.
// Optional sticky lost-event flag when EVT_OVF_EN is defined.
module event_collect_s
    import cdc_pkg::*;
#(
    parameter int CNT_W = cdc_pkg::CNT_W_DEFAULT
) (
    input  logic             clkb,
    input  logic             rst,
    input  logic             din,
    input  logic             clr,
    output logic             evt_valid,
    input  logic             evt_ready,
`ifdef EVT_OVF_EN
    output logic             evt_ovf,
`endif
    output logic [CNT_W-1:0] pend_cnt
);

    localparam logic [CNT_W-1:0] W_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] W_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_rise;
    logic             w_accept;
    logic             w_full;
    logic             w_drop;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;

    pulse_rise_det u_rise_det (
        .clkb (clkb),
        .rst  (rst),
        .din  (din),
        .rise (w_rise)
    );

    assign w_accept = r_valid & evt_ready;
    assign w_full   = (r_cnt == W_MAX);

    // Next pending count: clear, then rise/accept combinations
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_drop    = 1'b0;
        if (clr) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else if (w_rise && w_accept) begin
            w_cnt_nxt = r_cnt;
        end else if (w_rise) begin
            if (!w_full) begin
                w_cnt_nxt = r_cnt + W_ONE;
            end else begin
                w_drop = 1'b1;
            end
        end else if (w_accept) begin
            w_cnt_nxt = r_cnt - W_ONE;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Count and valid registered together so valid never sees din/evt_ready
    always_ff @(posedge clkb) begin
        if (!rst) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_valid <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != {CNT_W{1'b0}});
        end
    end

`ifdef EVT_OVF_EN
    logic r_ovf;

    // Sticky lost-event flag
    always_ff @(posedge clkb) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | w_drop;
        end
    end

    assign evt_ovf = r_ovf;
`else
    logic w_drop_unused;
    assign w_drop_unused = w_drop;
`endif

    assign pend_cnt  = r_cnt;
    assign evt_valid = r_valid;

endmodule

// File: tb/tb_event_collect_s.sv
// Scoreboard bench for event_collect_s: a reference model pushes expected state
// per driven cycle, popped and compared one edge later.
module tb_event_collect_s;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          clkb = 1'b0;
    logic          rst, din, clr, evt_ready;
    logic          evt_valid;
    logic [CW-1:0] pend_cnt;
    logic          evt_ovf_s;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int cnt;
        int valid;
        int ovf;
    } exp_t;
    exp_t sb_q[$];

    int m_cnt   = 0;
    int m_din_d = 0;
    int m_ovf   = 0;

    event_collect_s #(.CNT_W(CW)) dut (
        .clkb      (clkb),
        .rst       (rst),
        .din       (din),
        .clr       (clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
`ifdef EVT_OVF_EN
        .evt_ovf   (evt_ovf_s),
`endif
        .pend_cnt  (pend_cnt)
    );

`ifndef EVT_OVF_EN
    assign evt_ovf_s = 1'b0;
`endif

    always #5 clkb = ~clkb;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive one cycle, advance the model, push expectation, then compare after the edge
    task automatic step(input string tag, input logic r, input logic d,
                        input logic c, input logic rdy);
        exp_t e;
        int   rise, acc;
        rst = r; din = d; clr = c; evt_ready = rdy;
        if (!r) begin
            m_cnt = 0; m_din_d = 0; m_ovf = 0;
        end else begin
            rise = (d && !m_din_d) ? 1 : 0;
            acc  = (rdy && m_cnt != 0) ? 1 : 0;
            if (c) begin
                m_cnt = 0; m_ovf = 0;
            end else if (rise && acc) begin
                m_cnt = m_cnt;
            end else if (rise) begin
                if (m_cnt < MAX) m_cnt++;
                else m_ovf = 1;
            end else if (acc) begin
                m_cnt--;
            end
            m_din_d = d;
        end
        e.cnt = m_cnt; e.valid = (m_cnt != 0); e.ovf = m_ovf;
        sb_q.push_back(e);
        @(posedge clkb);
        #1;
        e = sb_q.pop_front();
        check_val({tag, ".cnt"}, int'(pend_cnt), e.cnt);
        check_val({tag, ".valid"}, int'(evt_valid), e.valid);
`ifdef EVT_OVF_EN
        check_val({tag, ".ovf"}, int'(evt_ovf_s), e.ovf);
`endif
    endtask

    initial begin
        rst = 1'b0; din = 1'b0; clr = 1'b0; evt_ready = 1'b0;
        @(posedge clkb); #1;

        for (int i = 0; i < 3; i++) step("rst_hold", 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("rst_cnt_const", int'(pend_cnt), 0);
        step("rst_release", 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("rst_release_cnt", int'(pend_cnt), 1);
        step("idle", 1'b1, 1'b0, 1'b0, 1'b0);
        step("drain0", 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("drain0_empty", int'(evt_valid), 0);

        // Two separated pulses, consumer stalled
        step("p1a", 1'b1, 1'b1, 1'b0, 1'b0);
        step("p1b", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("gap", 1'b1, 1'b0, 1'b0, 1'b0);
        step("p2", 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("two_pulses_cnt", int'(pend_cnt), 2);
        step("p2_low", 1'b1, 1'b0, 1'b0, 1'b0);

        step("drain_a", 1'b1, 1'b0, 1'b0, 1'b1);
        step("drain_b", 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("drained_valid", int'(evt_valid), 0);
        step("underflow", 1'b1, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            step("fill3_hi", 1'b1, 1'b1, 1'b0, 1'b0);
            step("fill3_lo", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step("rise_acc", 1'b1, 1'b1, 1'b0, 1'b1);
        check_val("rise_acc_cnt", int'(pend_cnt), 3);
        step("rise_acc_lo", 1'b1, 1'b0, 1'b0, 1'b0);
        step("clr3", 1'b1, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            step("sat_hi", 1'b1, 1'b1, 1'b0, 1'b0);
            step("sat_lo", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check_val("sat_cnt", int'(pend_cnt), MAX);
`ifdef EVT_OVF_EN
        check_val("sat_ovf", int'(evt_ovf_s), 1);
`endif
        step("sat_clr", 1'b1, 1'b0, 1'b1, 1'b0);
        check_val("sat_clr_cnt", int'(pend_cnt), 0);

        step("clr_rise", 1'b1, 1'b1, 1'b1, 1'b0);
        step("clr_rise_hold", 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("clr_rise_cnt", int'(pend_cnt), 0);
        step("clr_rise_lo", 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            step("rand", 1'b1, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
